fetch_prefetch: RTL and testbench
=================================

# fetch_prefetch

Parametrised instruction-fetch front end that replaces the single-register fetch stage. It keeps a fetch PC, issues instruction reads to memory with a request/grant/response handshake, and buffers returned instructions with their PCs in a small prefetch FIFO. Decode consumes the FIFO through a valid/ready handshake. A redirect from decode/ALU flushes the FIFO and discards any response still in flight.

## Interface
Parameters:
- ADDR_W, 32, width of PC and memory address; must be at least 3.
- DEPTH, 4, prefetch FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 00.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- redirect_ip  in  1  flush and restart fetch at redirect_addr_ip.
- redirect_addr_ip  in  ADDR_W  redirect target; bits [1:0] are ignored and treated as 00.
- instr_req_op  out  1  memory request valid.
- instr_addr_op  out  ADDR_W  address of the pending request.
- instr_gnt_ip  in  1  memory accepts the request this cycle.
- instr_rvalid_ip  in  1  response data valid.
- instr_rdata_ip  in  32  instruction word.
- dec_valid_op  out  1  FIFO head is valid.
- dec_ready_ip  in  1  decode accepts the head this cycle.
- dec_instr_op  out  32  instruction at the head.
- dec_pc_op  out  ADDR_W  PC of the head.
- dec_next_pc_op  out  ADDR_W  dec_pc_op + 4, combinational, mod 2^ADDR_W.

## Operation
- **Registers.**
  - fpc: next address to request.
  - req_addr: address of the outstanding request.
  - FSM state.
  - kill flag.
  - FIFO with count cnt.
- **FSM states.**
  - F_IDLE: no request pending.
  - F_REQ: instr_req_op=1, waiting for grant.
  - F_WAIT: granted, waiting for rvalid.
- **F_IDLE → F_REQ** when cnt < DEPTH after this cycle's pop. On entry, req_addr <= fpc.
- **F_REQ.**
  - instr_req_op and instr_addr_op stay stable until instr_gnt_ip=1, even across a redirect.
  - On grant: go to F_WAIT and set fpc <= req_addr + 4.
- **F_WAIT.**
  - On rvalid with kill=0: push {instr_rdata_ip, req_addr}.
  - On rvalid with kill=1: drop the data and clear kill.
  - After rvalid, go to F_REQ if space remains, otherwise F_IDLE.
  - Only one request is outstanding at any time. Space check: cnt + 1 ≤ DEPTH, counting the in-flight slot, so a push never overflows.
- **Pop.** The head is removed when dec_valid_op=1 and dec_ready_ip=1.
- **Redirect** (has priority over all other updates in the same cycle):
  - FIFO is flushed: cnt <= 0.
  - fpc <= {redirect_addr_ip[ADDR_W-1:2], 2'b00}.
  - If in F_REQ or F_WAIT, kill <= 1. A response arriving in the same cycle as the redirect is dropped.
  - A grant in the same cycle as a redirect is still honoured; that request's response is dropped.
  - From F_IDLE, the next cycle is F_REQ at the new target.
- **Simultaneous push and pop** on a full FIFO cannot occur (guaranteed by the space rule). Push and pop together at any other occupancy leave cnt unchanged.
- **Address arithmetic** wraps modulo 2^ADDR_W.

## Timing
- **Reset values:**
  - instr_req_op=0, instr_addr_op=RESET_PC.
  - dec_valid_op=0, dec_instr_op=0, dec_pc_op=0, dec_next_pc_op=4.
  - fpc=RESET_PC, kill=0, state F_IDLE.
- **Reset mid-transaction** abandons the transaction. Responses arriving after reset are ignored because the state is not F_WAIT.
- First instr_req_op=1 appears one cycle after reset deasserts.
- **Latency:** response in cycle N → dec_valid_op=1 in cycle N+1. There is no bypass.
- **Best-case throughput** (gnt in the request cycle, rvalid one cycle later): one instruction every 2 cycles.
- A redirect in cycle N gives dec_valid_op=0 in cycle N+1.
- The first new request is in cycle N+1 if idle. Otherwise it follows completion of the killed transaction.

## Structure
- CORE_PKG gains:
  - typedef fetch_state_e {F_IDLE, F_REQ, F_WAIT}.
  - localparam NOP_INSTR = 32'h00000013, for decode use.
- Existing pc_mux enums stay in CORE_PKG. Decode converts pc_mux/offset into redirect_ip/redirect_addr_ip.
- One sub-module, fetch_fifo: a synchronous FIFO parametrised on width and DEPTH, with push, pop, flush, count, full and empty. Entry = {pc, instr}. Reset clears the pointers and the head output.

## Test plan
- **Reset and first fetch:** reset, release; gnt tied 1, rvalid one cycle after gnt, rdata=addr ^ 32'hA5A5_0000 → requests to 0, 4, 8, …; dec_pc_op 0, 4, 8 in order; dec_next_pc_op = dec_pc_op + 4.
- **Backpressure:** dec_ready_ip=0, DEPTH=4 → exactly 4 responses accepted; instr_req_op stays 0 after the 4th. Then ready=1 for one cycle → exactly one new request.
- **Redirect in F_WAIT:** redirect to 0x100 while a request to 0x8 awaits rvalid; rvalid arrives 2 cycles later → data is dropped, FIFO is empty, next request to 0x100, and the first dec_pc_op is 0x100.
- **Redirect with misaligned target:** redirect_addr_ip=0x203 in the same cycle as gnt → that response is dropped; next request to 0x200.
- **Grant stalls:** gnt withheld 5 cycles → instr_req_op and instr_addr_op stay stable throughout. A redirect during the stall does not change instr_addr_op before gnt.
- **Async reset in F_WAIT:** assert reset between clock edges → instr_req_op=0 immediately; a later stale rvalid is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_pkg.sv
// fetch_prefetch_pkg: types and constants shared by the fetch front end and decode.
package fetch_prefetch_pkg;

    typedef enum logic [1:0] {PC_NEXT, PC_BRANCH, PC_JUMP, PC_TRAP} pc_mux_e;

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head is read straight from storage.
module fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [W-1:0]            wdata_i,
    output logic [W-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    full_o,
    output logic                    empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;

    assign wr      = push_i && !full_o;
    assign rd      = pop_i && !empty_o;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr) mem_q[wptr_q] <= wdata_i;
            wptr_q <= wptr_q + AW'(wr);
            rptr_q <= rptr_q + AW'(rd);
            cnt_q  <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: PC sequencer issuing one outstanding instruction read at a time
// into a prefetch FIFO that decode drains via valid/ready.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_ip,
    input  logic [ADDR_W-1:0] redirect_addr_ip,
    output logic              instr_req_op,
    output logic [ADDR_W-1:0] instr_addr_op,
    input  logic              instr_gnt_ip,
    input  logic              instr_rvalid_ip,
    input  logic [31:0]       instr_rdata_ip,
    output logic              dec_valid_op,
    input  logic              dec_ready_ip,
    output logic [31:0]       dec_instr_op,
    output logic [ADDR_W-1:0] dec_pc_op,
    output logic [ADDR_W-1:0] dec_next_pc_op
);
    localparam int                CW   = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d, req_addr_q, req_addr_d, target;
    logic              kill_q, kill_d, push, pop, full, empty;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [ADDR_W+31:0] head;

    assign target         = redirect_addr_ip & ~ADDR_W'(3);
    assign pop            = dec_valid_op && dec_ready_ip;
    assign push           = state_q == F_WAIT && instr_rvalid_ip && !kill_q && !redirect_ip;
    assign cnt_nxt        = cnt - CW'(pop) + CW'(push);
    assign instr_req_op   = state_q == F_REQ;
    assign instr_addr_op  = req_addr_q;
    assign dec_valid_op   = !empty;
    assign dec_pc_op      = head[ADDR_W+31:32];
    assign dec_instr_op   = head[31:0];
    assign dec_next_pc_op = dec_pc_op + FOUR;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        req_addr_d = req_addr_q;
        kill_d     = kill_q;
        unique case (state_q)
            F_IDLE: state_d = (redirect_ip || !full || pop) ? F_REQ : F_IDLE;
            F_REQ: if (instr_gnt_ip) begin
                state_d = F_WAIT;
                // a redirect seen while stalled already holds the new target in fpc
                fpc_d   = kill_q ? fpc_q : req_addr_q + FOUR;
            end
            F_WAIT: if (instr_rvalid_ip) begin
                state_d = (redirect_ip || cnt_nxt < CW'(DEPTH)) ? F_REQ : F_IDLE;
                kill_d  = 1'b0;
            end
            default: state_d = F_IDLE;
        endcase
        if (redirect_ip) begin
            fpc_d = target;
            if (state_q == F_REQ || (state_q == F_WAIT && !instr_rvalid_ip)) kill_d = 1'b1;
        end
        if (state_d == F_REQ && state_q != F_REQ) req_addr_d = fpc_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= F_IDLE;
            fpc_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            req_addr_q <= req_addr_d;
            kill_q     <= kill_d;
        end
    end

    fetch_fifo #(.W(ADDR_W + 32), .DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_ip),
        .wdata_i ({req_addr_q, instr_rdata_ip}),
        .rdata_o (head),
        .count_o (cnt),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed phases plus random traffic against a transaction-level fetch model.
module tb_fetch_prefetch;
    localparam int          D = 4;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clock = 1'b0, reset = 1'b1;
    logic        redirect, gnt, rvalid, ready, req, dvalid;
    logic [31:0] redirect_addr, rdata, addr, dinstr, dpc, dnpc;

    always #5 clock = ~clock;

    fetch_prefetch #(.ADDR_W(32), .DEPTH(D), .RESET_PC(32'h0)) dut (
        .clock            (clock),
        .reset            (reset),
        .redirect_ip      (redirect),
        .redirect_addr_ip (redirect_addr),
        .instr_req_op     (req),
        .instr_addr_op    (addr),
        .instr_gnt_ip     (gnt),
        .instr_rvalid_ip  (rvalid),
        .instr_rdata_ip   (rdata),
        .dec_valid_op     (dvalid),
        .dec_ready_ip     (ready),
        .dec_instr_op     (dinstr),
        .dec_pc_op        (dpc),
        .dec_next_pc_op   (dnpc)
    );

    int n_cmp = 0, n_bad = 0;
    logic [31:0] q[$];
    logic [31:0] exp_fetch, out_addr, last_gnt, prev_addr, force_tgt, a0;
    bit   out_v, out_dead, out_stale, pend_dead, prev_stall, force_redir, force_on_gnt;
    int   out_timer, n_gnt, n_pop;
    int   p_gnt = 100, p_ready = 100, p_redir = 0, lat_lo = 0, lat_hi = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs, act as memory/decode/redirector, advance the model.
    task automatic cycle();
        bit rsp, g, pop, rd, fr;
        logic [31:0] tgt, np;
        @(negedge clock);
        chk("dec_valid", dvalid, q.size() > 0);
        if (q.size() > 0) begin
            np = q[0] + 32'd4;
            chk("dec_pc", dpc, q[0]);
            chk("dec_instr", dinstr, q[0] ^ K);
            chk("dec_next_pc", dnpc, np);
        end
        if (prev_stall) begin
            chk("req_hold", req, 1);
            chk("addr_hold", addr, prev_addr);
        end
        chk("one_outstanding", req && out_v && !out_stale, 0);
        rsp = out_v && out_timer == 0;
        if (out_v && out_timer > 0) out_timer--;
        g   = !out_v && ($urandom_range(0, 99) < p_gnt);
        fr  = force_redir && (!force_on_gnt || (req && g));
        rd  = fr || ($urandom_range(0, 999) < p_redir);
        tgt = fr ? force_tgt : 32'($urandom_range(0, 4095));
        if (fr) force_redir = 0;
        rvalid        = rsp;
        rdata         = rsp ? out_addr ^ K : $urandom;
        gnt           = g;
        ready         = $urandom_range(0, 99) < p_ready;
        redirect      = rd;
        redirect_addr = tgt;
        pop           = dvalid && ready;
        if (rd) q.delete();
        else begin
            if (pop) begin
                void'(q.pop_front());
                n_pop++;
            end
            if (rsp && !out_dead) begin
                chk("no_overflow", q.size() < D, 1);
                q.push_back(out_addr);
            end
        end
        if (rsp) out_v = 0;
        if (req && g) begin
            if (!pend_dead) begin
                chk("req_addr", addr, exp_fetch);
                exp_fetch = addr + 32'd4;
            end
            n_gnt++;
            last_gnt  = addr;
            out_v     = 1;
            out_addr  = addr;
            out_dead  = pend_dead || rd;
            out_stale = 0;
            out_timer = $urandom_range(lat_lo, lat_hi);
            pend_dead = 0;
        end
        if (rd) begin
            exp_fetch = tgt & ~32'h3;
            if (out_v) out_dead = 1;
            if (req && !g) pend_dead = 1;
        end
        prev_stall = req && !g;
        prev_addr  = addr;
        @(posedge clock);
    endtask

    task automatic do_reset();
        reset = 1; redirect = 0; gnt = 0; rvalid = 0; ready = 0;
        redirect_addr = '0; rdata = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_valid", dvalid, 0);
        chk("rst_instr", dinstr, 0);
        chk("rst_pc", dpc, 0);
        chk("rst_next_pc", dnpc, 32'd4);
        q.delete();
        exp_fetch = '0; pend_dead = 0; prev_stall = 0; out_v = 0; out_stale = 0;
        n_gnt = 0; n_pop = 0; force_redir = 0;
        reset = 0;
        @(posedge clock);
        #1 chk("first_req", req, 1);
    endtask

    task automatic wait_gnt(input int k);
        int start = n_gnt;
        for (int i = 0; i < 60 && n_gnt < start + k; i++) cycle();
        chk("gnt_timeout", n_gnt >= start + k, 1);
    endtask

    initial begin
        do_reset();
        repeat (12) cycle();
        chk("stream_grants", n_gnt, 6);

        do_reset();
        p_ready = 0;
        repeat (20) cycle();
        chk("bp_grants", n_gnt, 4);
        #1 chk("bp_req_low", req, 0);
        p_ready = 100;
        cycle();
        p_ready = 0;
        repeat (10) cycle();
        chk("bp_one_more", n_gnt, 5);

        do_reset();
        p_ready = 100; lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 40 && !(out_v && out_addr == 32'h8); i++) cycle();
        chk("reach_8", out_addr, 32'h8);
        force_redir = 1; force_on_gnt = 0; force_tgt = 32'h100;
        cycle();
        wait_gnt(1);
        chk("redir_wait_next", last_gnt, 32'h100);
        for (int i = 0; i < 20; i++) begin
            cycle();
            #1;
            if (dvalid) break;
        end
        chk("redir_valid_seen", dvalid, 1);
        chk("redir_first_pc", dpc, 32'h100);

        lat_lo = 1; lat_hi = 1;
        force_redir = 1; force_on_gnt = 1; force_tgt = 32'h203;
        for (int i = 0; i < 20 && force_redir; i++) cycle();
        chk("redir_gnt_taken", force_redir, 0);
        wait_gnt(1);
        chk("misalign_req", last_gnt, 32'h200);

        p_gnt = 0; lat_lo = 0; lat_hi = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            #1;
            if (req) break;
        end
        a0 = addr;
        repeat (2) cycle();
        force_redir = 1; force_on_gnt = 0; force_tgt = 32'h300;
        repeat (3) cycle();
        #1;
        chk("stall_req", req, 1);
        chk("stall_addr", addr, a0);
        p_gnt = 100;
        wait_gnt(2);
        chk("stall_redir_req", last_gnt, 32'h300);

        p_ready = 0;
        wait_gnt(2);
        lat_lo = 6; lat_hi = 6;
        wait_gnt(1);
        #2 reset = 1;
        #1;
        chk("arst_req", req, 0);
        chk("arst_valid", dvalid, 0);
        chk("arst_addr", addr, 0);
        chk("arst_pc", dpc, 0);
        @(negedge clock);
        reset = 0; gnt = 0; rvalid = 0; redirect = 0;
        q.delete();
        exp_fetch = '0; pend_dead = 0; prev_stall = 0; out_dead = 1; out_stale = 1;
        p_ready = 100; lat_lo = 0; lat_hi = 0;
        wait_gnt(1);
        chk("arst_restart", last_gnt, 32'h0);

        p_gnt = 60; lat_lo = 0; lat_hi = 3; p_ready = 70; p_redir = 30;
        repeat (3000) cycle();
        p_redir = 0; p_gnt = 100; p_ready = 100;
        force_redir = 1; force_on_gnt = 0; force_tgt = 32'hFFFF_FFF6;
        repeat (40) cycle();
        chk("progress", n_pop > 200, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
